// File: rtl/exec_pkg.sv
// Shared opcodes, FSM state type and status-bit positions for the exec_unit slice.
package exec_pkg;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_XOR = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_NOR = 4'b0100;
    localparam logic [3:0] OP_SL  = 4'b0101;
    localparam logic [3:0] OP_SR  = 4'b0110;
    localparam logic [3:0] OP_SUB = 4'b0111;
    localparam logic [3:0] OP_SLT = 4'b1000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_SHIFT
    } state_e;

    localparam int STAT_V   = 4;
    localparam int STAT_C   = 3;
    localparam int STAT_N   = 2;
    localparam int STAT_Z   = 1;
    localparam int STAT_ERR = 0;

endpackage

// File: rtl/exec_regfile.sv
// Register file: two combinational read ports, a debug read port, one synchronous
// write port, async reset to zero, x0 hardwired to zero.
module exec_regfile #(
    parameter  int DATA_W    = 32,
    parameter  int REG_COUNT = 32,
    localparam int RA_W      = $clog2(REG_COUNT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [RA_W-1:0]   ra1_i,
    output logic [DATA_W-1:0] rd1_o,
    input  logic [RA_W-1:0]   ra2_i,
    output logic [DATA_W-1:0] rd2_o,
    input  logic [RA_W-1:0]   dbg_addr_i,
    output logic [DATA_W-1:0] dbg_data_o,
    input  logic              we_i,
    input  logic [RA_W-1:0]   wa_i,
    input  logic [DATA_W-1:0] wd_i
);

    logic [DATA_W-1:0] mem_q [REG_COUNT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i && (wa_i != '0)) begin
            mem_q[wa_i] <= wd_i;
        end
    end

    assign rd1_o      = (ra1_i == '0)      ? '0 : mem_q[ra1_i];
    assign rd2_o      = (ra2_i == '0)      ? '0 : mem_q[ra2_i];
    assign dbg_data_o = (dbg_addr_i == '0) ? '0 : mem_q[dbg_addr_i];

endmodule

// File: rtl/exec_unit.sv
// Multi-cycle execute unit: register file, ALU, status flags and a valid/ready issue port.
// Define EXEC_UNIT_BARREL_EN to replace the iterative shifter with a single-cycle barrel shift.
module exec_unit
    import exec_pkg::*;
#(
    parameter  int DATA_W    = 32,
    parameter  int REG_COUNT = 32,
    localparam int SH_W      = $clog2(DATA_W),
    localparam int RA_W      = $clog2(REG_COUNT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        aluop,
    input  logic              alusrc,
    input  logic              regrw,
    input  logic [RA_W-1:0]   rs1,
    input  logic [RA_W-1:0]   rs2,
    input  logic [RA_W-1:0]   rd,
    input  logic [DATA_W-1:0] imm,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic [4:0]        status,
    input  logic [RA_W-1:0]   dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    state_e            state_q, state_d;
    logic [3:0]        op_q, op_d;
    logic              regrw_q, regrw_d;
    logic [RA_W-1:0]   rd_q, rd_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
    logic              done_q;
    logic [DATA_W-1:0] result_q;
    logic [4:0]        status_q, status_d;

    logic [DATA_W-1:0] rs1_data, rs2_data, b_sel;
    logic [DATA_W:0]   sum, diff, shl, shr;
    logic [DATA_W-1:0] alu_res;
    logic              alu_c, alu_v, alu_legal, slt;
    logic              finish, fin_c, fin_v, fin_legal;
    logic [DATA_W-1:0] fin_res;

`ifndef EXEC_UNIT_BARREL_EN
    logic [DATA_W-1:0] acc_q, acc_d, sh_next;
    logic [SH_W-1:0]   cnt_q, cnt_d;
    logic              sh_out;
`endif

    exec_regfile #(.DATA_W(DATA_W), .REG_COUNT(REG_COUNT)) u_rf (
        .clk        (clk),
        .rst        (rst),
        .ra1_i      (rs1),
        .rd1_o      (rs1_data),
        .ra2_i      (rs2),
        .rd2_o      (rs2_data),
        .dbg_addr_i (dbg_addr),
        .dbg_data_o (dbg_data),
        .we_i       (finish && regrw_q && fin_legal),
        .wa_i       (rd_q),
        .wd_i       (fin_res)
    );

    assign b_sel    = alusrc ? imm : rs2_data;
    assign in_ready = (state_q == ST_IDLE);

    // The extra top bit of shl/shr catches the last bit shifted out; it stays 0 for a zero shift.
    always_comb begin
        sum       = {1'b0, a_q} + {1'b0, b_q};
        diff      = {1'b0, a_q} - {1'b0, b_q};
        shl       = {1'b0, a_q} << b_q[SH_W-1:0];
        shr       = {a_q, 1'b0} >> b_q[SH_W-1:0];
        slt       = $signed(a_q) < $signed(b_q);
        alu_res   = '0;
        alu_c     = 1'b0;
        alu_v     = 1'b0;
        alu_legal = 1'b1;
        case (op_q)
            OP_ADD: begin
                alu_res = sum[DATA_W-1:0];
                alu_c   = sum[DATA_W];
                alu_v   = (a_q[DATA_W-1] == b_q[DATA_W-1]) && (sum[DATA_W-1] != a_q[DATA_W-1]);
            end
            OP_XOR: alu_res = a_q ^ b_q;
            OP_AND: alu_res = a_q & b_q;
            OP_OR:  alu_res = a_q | b_q;
            OP_NOR: alu_res = ~(a_q | b_q);
            OP_SL: begin
                alu_res = shl[DATA_W-1:0];
                alu_c   = shl[DATA_W];
            end
            OP_SR: begin
                alu_res = shr[DATA_W:1];
                alu_c   = shr[0];
            end
            OP_SUB: begin
                alu_res = diff[DATA_W-1:0];
                alu_c   = ~diff[DATA_W];
                alu_v   = (a_q[DATA_W-1] != b_q[DATA_W-1]) && (diff[DATA_W-1] != a_q[DATA_W-1]);
            end
            OP_SLT: begin
                alu_res = {{(DATA_W-1){1'b0}}, slt};
                alu_c   = ~diff[DATA_W];
            end
            default: alu_legal = 1'b0;
        endcase
    end

`ifndef EXEC_UNIT_BARREL_EN
    assign sh_next = (op_q == OP_SL) ? (acc_q << 1) : (acc_q >> 1);
    assign sh_out  = (op_q == OP_SL) ? acc_q[DATA_W-1] : acc_q[0];
`endif

    always_comb begin
        finish    = 1'b0;
        fin_res   = alu_res;
        fin_c     = alu_c;
        fin_v     = alu_v;
        fin_legal = alu_legal;
        case (state_q)
            ST_EXEC: finish = 1'b1;
`ifndef EXEC_UNIT_BARREL_EN
            ST_SHIFT: begin
                finish    = (cnt_q == SH_W'(1));
                fin_res   = sh_next;
                fin_c     = sh_out;
                fin_v     = 1'b0;
                fin_legal = 1'b1;
            end
`endif
            default: finish = 1'b0;
        endcase
        if (!fin_legal) begin
            fin_res  = '0;
            status_d = 5'b00011;
        end else begin
            status_d           = '0;
            status_d[STAT_V]   = fin_v;
            status_d[STAT_C]   = fin_c;
            status_d[STAT_N]   = fin_res[DATA_W-1];
            status_d[STAT_Z]   = (fin_res == '0);
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        regrw_d = regrw_q;
        rd_d    = rd_q;
        a_d     = a_q;
        b_d     = b_q;
`ifndef EXEC_UNIT_BARREL_EN
        acc_d   = acc_q;
        cnt_d   = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    op_d    = aluop;
                    regrw_d = regrw;
                    rd_d    = rd;
                    a_d     = rs1_data;
                    b_d     = b_sel;
                    state_d = ST_EXEC;
`ifndef EXEC_UNIT_BARREL_EN
                    acc_d   = rs1_data;
                    cnt_d   = b_sel[SH_W-1:0];
                    if (((aluop == OP_SL) || (aluop == OP_SR)) && (b_sel[SH_W-1:0] != '0)) begin
                        state_d = ST_SHIFT;
                    end
`endif
                end
            end
            ST_EXEC: state_d = ST_IDLE;
`ifndef EXEC_UNIT_BARREL_EN
            ST_SHIFT: begin
                acc_d = sh_next;
                cnt_d = cnt_q - SH_W'(1);
                if (cnt_q == SH_W'(1)) begin
                    state_d = ST_IDLE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_ADD;
            regrw_q  <= 1'b0;
            rd_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            done_q   <= 1'b0;
            result_q <= '0;
            status_q <= '0;
`ifndef EXEC_UNIT_BARREL_EN
            acc_q    <= '0;
            cnt_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            regrw_q <= regrw_d;
            rd_q    <= rd_d;
            a_q     <= a_d;
            b_q     <= b_d;
            done_q  <= finish;
            if (finish) begin
                result_q <= fin_res;
                status_q <= status_d;
            end
`ifndef EXEC_UNIT_BARREL_EN
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign done   = done_q;
    assign result = result_q;
    assign status = status_q;

endmodule

// File: tb/tb_exec_unit.sv
// Directed self-checking bench for exec_unit with hand-computed expected values.
module tb_exec_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  aluop = 4'b0;
    logic        alusrc = 1'b0;
    logic        regrw = 1'b0;
    logic [4:0]  rs1 = '0, rs2 = '0, rd = '0;
    logic [31:0] imm = '0;
    logic        done;
    logic [31:0] result;
    logic [4:0]  status;
    logic [4:0]  dbg_addr = '0;
    logic [31:0] dbg_data;

    int errors = 0;
    int checks = 0;
    int lat, busy;
    int shLat;
    bit anyNonZero;
    bit sawDone;

    exec_unit dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .aluop    (aluop),
        .alusrc   (alusrc),
        .regrw    (regrw),
        .rs1      (rs1),
        .rs2      (rs2),
        .rd       (rd),
        .imm      (imm),
        .done     (done),
        .result   (result),
        .status   (status),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] op, input logic src, input logic rw,
                                 input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rdd,
                                 input logic [31:0] im, output int latency, output int busyCycles);
        @(negedge clk);
        aluop = op; alusrc = src; regrw = rw; rs1 = r1; rs2 = r2; rd = rdd; imm = im;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        latency = 0;
        busyCycles = 0;
        while (!done && latency < 100) begin
            if (!in_ready) busyCycles++;
            @(posedge clk);
            latency++;
            @(negedge clk);
        end
        if (latency >= 100) checkOutput("done_timeout", 64'(latency), 64'd0);
    endtask

    task automatic readReg(input logic [4:0] a, output logic [31:0] v);
        dbg_addr = a;
        #1;
        v = dbg_data;
    endtask

    initial begin
        logic [31:0] v;
`ifdef EXEC_UNIT_BARREL_EN
        shLat = 1;
`else
        shLat = 4;
`endif
        repeat (3) @(negedge clk);
        checkOutput("rst_ready", 64'(in_ready), 64'd1);
        checkOutput("rst_done", 64'(done), 64'd0);
        checkOutput("rst_result", 64'(result), 64'd0);
        checkOutput("rst_status", 64'(status), 64'd0);
        rst = 1'b0;
        anyNonZero = 1'b0;
        for (int i = 0; i < 32; i++) begin
            readReg(5'(i), v);
            if (v != 32'd0) anyNonZero = 1'b1;
        end
        checkOutput("rst_regs_zero", 64'(anyNonZero), 64'd0);

        // ADD x1 = x0 + 5
        applyStimulus(4'b0000, 1'b1, 1'b1, 5'd0, 5'd0, 5'd1, 32'd5, lat, busy);
        checkOutput("add_lat", 64'(lat), 64'd1);
        checkOutput("add_res", 64'(result), 64'd5);
        checkOutput("add_status", 64'(status), 64'd0);
        readReg(5'd1, v);
        checkOutput("add_x1", 64'(v), 64'd5);

        // x1 = 0x8000_0000 via OR, then SUB x2 = x1 - 1
        applyStimulus(4'b0011, 1'b1, 1'b1, 5'd0, 5'd0, 5'd1, 32'h8000_0000, lat, busy);
        checkOutput("or_res", 64'(result), 64'h8000_0000);
        checkOutput("or_status", 64'(status), 64'b00100);
        applyStimulus(4'b0111, 1'b1, 1'b1, 5'd1, 5'd0, 5'd2, 32'd1, lat, busy);
        checkOutput("sub_res", 64'(result), 64'h7FFF_FFFF);
        checkOutput("sub_status", 64'(status), 64'b11000);
        readReg(5'd2, v);
        checkOutput("sub_x2", 64'(v), 64'h7FFF_FFFF);

        // ADD x7 = x1 + x1 : carry, overflow, zero
        applyStimulus(4'b0000, 1'b0, 1'b1, 5'd1, 5'd1, 5'd7, 32'd0, lat, busy);
        checkOutput("addc_res", 64'(result), 64'd0);
        checkOutput("addc_status", 64'(status), 64'b11010);

        // SLT both orders on x1 (negative) and x2 (positive)
        applyStimulus(4'b1000, 1'b0, 1'b1, 5'd2, 5'd1, 5'd8, 32'd0, lat, busy);
        checkOutput("slt_pn_res", 64'(result), 64'd0);
        checkOutput("slt_pn_status", 64'(status), 64'b00010);
        applyStimulus(4'b1000, 1'b0, 1'b1, 5'd1, 5'd2, 5'd8, 32'd0, lat, busy);
        checkOutput("slt_np_res", 64'(result), 64'd1);
        checkOutput("slt_np_status", 64'(status), 64'b01000);

        // x3 = 1, SL x4 = x3 << 4
        applyStimulus(4'b0000, 1'b1, 1'b1, 5'd0, 5'd0, 5'd3, 32'd1, lat, busy);
        applyStimulus(4'b0101, 1'b1, 1'b1, 5'd3, 5'd0, 5'd4, 32'd4, lat, busy);
        checkOutput("sl_lat", 64'(lat), 64'(shLat));
        checkOutput("sl_busy", 64'(busy), 64'(shLat));
        checkOutput("sl_ready_done", 64'(in_ready), 64'd1);
        checkOutput("sl_res", 64'(result), 64'h10);
        checkOutput("sl_status", 64'(status), 64'd0);
        readReg(5'd4, v);
        checkOutput("sl_x4", 64'(v), 64'h10);

        // SR x10 = x2 >> 4 : last bit out is 1
        applyStimulus(4'b0110, 1'b1, 1'b1, 5'd2, 5'd0, 5'd10, 32'd4, lat, busy);
        checkOutput("sr_lat", 64'(lat), 64'(shLat));
        checkOutput("sr_res", 64'(result), 64'h07FF_FFFF);
        checkOutput("sr_status", 64'(status), 64'b01000);

        // SL by imm 32 -> amount 0: EXEC path, C = 0
        applyStimulus(4'b0101, 1'b1, 1'b1, 5'd2, 5'd0, 5'd11, 32'd32, lat, busy);
        checkOutput("sl0_lat", 64'(lat), 64'd1);
        checkOutput("sl0_res", 64'(result), 64'h7FFF_FFFF);
        checkOutput("sl0_status", 64'(status), 64'd0);

        // NOR / AND / XOR chain
        applyStimulus(4'b0100, 1'b1, 1'b1, 5'd0, 5'd0, 5'd12, 32'd0, lat, busy);
        checkOutput("nor_res", 64'(result), 64'hFFFF_FFFF);
        checkOutput("nor_status", 64'(status), 64'b00100);
        applyStimulus(4'b0010, 1'b1, 1'b1, 5'd12, 5'd0, 5'd13, 32'hF0, lat, busy);
        checkOutput("and_res", 64'(result), 64'hF0);
        applyStimulus(4'b0001, 1'b1, 1'b1, 5'd13, 5'd0, 5'd14, 32'hFF, lat, busy);
        checkOutput("xor_res", 64'(result), 64'h0F);

        // Illegal op must not overwrite x5 (preloaded with 7)
        applyStimulus(4'b0000, 1'b1, 1'b1, 5'd0, 5'd0, 5'd5, 32'd7, lat, busy);
        applyStimulus(4'b1111, 1'b1, 1'b1, 5'd3, 5'd0, 5'd5, 32'd9, lat, busy);
        checkOutput("ill_lat", 64'(lat), 64'd1);
        checkOutput("ill_res", 64'(result), 64'd0);
        checkOutput("ill_status", 64'(status), 64'b00011);
        readReg(5'd5, v);
        checkOutput("ill_x5", 64'(v), 64'd7);

        // Write to x0 is dropped
        applyStimulus(4'b0000, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 32'd9, lat, busy);
        checkOutput("x0_res", 64'(result), 64'd9);
        readReg(5'd0, v);
        checkOutput("x0_dbg", 64'(v), 64'd0);

        // SR x15 = x1 >> 20, reset 3 cycles after accept
        @(negedge clk);
        aluop = 4'b0110; alusrc = 1'b1; regrw = 1'b1; rs1 = 5'd1; rd = 5'd15; imm = 32'd20;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        sawDone = 1'b0;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            if (done) sawDone = 1'b1;
        end
        rst = 1'b1;
        repeat (25) begin
            @(negedge clk);
            if (done) sawDone = 1'b1;
        end
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done) sawDone = 1'b1;
        end
        checkOutput("abort_no_done", 64'(sawDone), 64'd0);
        checkOutput("abort_ready", 64'(in_ready), 64'd1);
        readReg(5'd15, v);
        checkOutput("abort_x15", 64'(v), 64'd0);
        readReg(5'd1, v);
        checkOutput("abort_x1_reset", 64'(v), 64'd0);
        checkOutput("abort_result", 64'(result), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
